// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and defaults for the instruction-fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int c_DEF_ADDRESS_WIDTH = 32;
    localparam int c_DEF_DATA_WIDTH    = 32;

    typedef enum logic {
        REL = 1'b0,
        ABS = 1'b1
    } redirect_mode_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1
    } fetch_state_e;

    // Default-width packet; the top re-declares it at its own widths.
    typedef struct packed {
        logic [c_DEF_DATA_WIDTH-1:0]    instr;
        logic [c_DEF_ADDRESS_WIDTH-1:0] pc;
    } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_buf
// Brief    : Two-entry (output + skid) valid/ready buffer with sync flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter type PKT_T = fetch_pkt_t
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    input  PKT_T in_pkt,
    output logic out_valid,
    output PKT_T out_pkt,
    input  logic out_ready,
    output logic skid_valid
);

    logic r_out_valid;
    logic r_skid_valid;
    PKT_T r_out_pkt;
    PKT_T r_skid_pkt;
    logic w_out_free;

    // The output slot can take new data when empty or being consumed.
    assign w_out_free = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_pkt    <= '0;
            r_skid_pkt   <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_pkt    <= r_skid_pkt;
                r_skid_valid <= in_valid;
                if (in_valid) begin
                    r_skid_pkt <= in_pkt;
                end
            end else begin
                r_out_valid <= in_valid;
                if (in_valid) begin
                    r_out_pkt <= in_pkt;
                end
            end
        end else if (in_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_pkt   <= in_pkt;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_pkt    = r_out_pkt;
    assign skid_valid = r_skid_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : PC owner, imem request/credit logic and redirect handling.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = c_DEF_ADDRESS_WIDTH,
    parameter int                       DATA_WIDTH    = c_DEF_DATA_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
    parameter int                       PC_STEP       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic                     redirect_mode,
    input  logic [ADDRESS_WIDTH-1:0] imm_op,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    output logic                     imem_req,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    instr;
        logic [ADDRESS_WIDTH-1:0] pc;
    } pkt_t;

    localparam logic [ADDRESS_WIDTH-1:0] c_STEP       = ADDRESS_WIDTH'(PC_STEP);
    localparam logic [ADDRESS_WIDTH-1:0] c_ALIGN_MASK = ~(c_STEP - ADDRESS_WIDTH'(1));
    localparam logic [1:0]               c_ST_RUN     = RUN;
    localparam logic [1:0]               c_ST_FLUSH   = FLUSH;

    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [ADDRESS_WIDTH-1:0] r_req_pc;
    logic                     r_inflight;
    logic [1:0]               r_state;

    logic                     w_accept;
    logic                     w_redirect;
    logic [ADDRESS_WIDTH-1:0] w_rel_target;
    logic [ADDRESS_WIDTH-1:0] w_raw_target;
    logic [ADDRESS_WIDTH-1:0] w_target;
    logic                     w_skid_valid;
    logic [1:0]               w_occ;
    logic                     w_room;
    logic                     w_resp_valid;
    pkt_t                     w_resp_pkt;
    pkt_t                     w_out_pkt;

    assign w_accept     = instr_valid & instr_ready;
    assign w_redirect   = redirect_valid & w_accept;
    assign w_rel_target = instr_pc + imm_op;
    assign w_raw_target = (redirect_mode_e'(redirect_mode) == ABS) ? imm_op : w_rel_target;
    assign w_target     = w_raw_target & c_ALIGN_MASK;

    // Everything already requested but not yet consumed must fit in the
    // two buffer slots, counting the slot freed by this cycle's accept.
    assign w_occ  = {1'b0, instr_valid} + {1'b0, w_skid_valid} + {1'b0, r_inflight};
    assign w_room = (w_occ - {1'b0, w_accept}) < 2'd2;

    assign imem_req  = !rst && w_room && !w_redirect;
    assign imem_addr = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= imem_req;
            if (w_redirect) begin
                r_pc <= w_target;
            end else if (imem_req) begin
                r_pc     <= r_pc + c_STEP;
                r_req_pc <= r_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RUN;
        end else begin
            case (r_state)
                c_ST_RUN:   r_state <= w_redirect ? c_ST_FLUSH : c_ST_RUN;
                c_ST_FLUSH: r_state <= c_ST_RUN;
                default:    r_state <= c_ST_RUN;
            endcase
        end
    end

    // A response landing during FLUSH belongs to the abandoned path.
    assign w_resp_valid = r_inflight && (r_state == c_ST_RUN);
    assign w_resp_pkt   = '{instr: imem_rdata, pc: r_req_pc};

    fetch_skid_buf #(
        .PKT_T (pkt_t)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush      (w_redirect),
        .in_valid   (w_resp_valid),
        .in_pkt     (w_resp_pkt),
        .out_valid  (instr_valid),
        .out_pkt    (w_out_pkt),
        .out_ready  (instr_ready),
        .skid_valid (w_skid_valid)
    );

    assign instr    = w_out_pkt.instr;
    assign instr_pc = w_out_pkt.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed + randomized check of fetch_unit against a stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic        redirect_mode = 1'b0;
    logic [7:0]  imm_op = '0;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    fetch_unit #(
        .ADDRESS_WIDTH (8),
        .DATA_WIDTH    (32),
        .RESET_PC      (8'h00),
        .PC_STEP       (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_mode  (redirect_mode),
        .imm_op         (imm_op),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [7:0] a);
        return 32'h1000 + 32'(a[7:2]);
    endfunction

    // Synchronous ROM; garbage when no read was issued.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= rom(imem_addr);
        else          imem_rdata <= $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: what the fetch front end owes decode, in program order.
    logic       have_reset = 1'b0;
    logic       prev_rst   = 1'b0;
    int         m_since    = 0;
    int         m_out      = 0;
    logic [7:0] m_exp_pc   = '0;
    logic [7:0] m_fetch_pc = '0;
    logic       m_valid, m_acc, m_redir, m_req;
    logic [7:0] m_tgt;

    always @(negedge clk) begin
        if (rst) begin
            if (prev_rst) begin
                chk("m_rst_valid", 32'(instr_valid), 32'd0);
                chk("m_rst_instr", instr, 32'd0);
                chk("m_rst_pc", 32'(instr_pc), 32'd0);
            end
            chk("m_rst_req", 32'(imem_req), 32'd0);
            m_since    = 0;
            m_out      = 0;
            m_exp_pc   = 8'h00;
            m_fetch_pc = 8'h00;
            have_reset = 1'b1;
        end else if (have_reset) begin
            m_valid = (m_since >= 2);
            m_acc   = m_valid && instr_ready;
            m_redir = m_acc && redirect_valid;
            m_req   = !m_redir && ((m_out - int'(m_acc)) < 2);
            chk("m_valid", 32'(instr_valid), 32'(m_valid));
            if (m_valid) begin
                chk("m_pc", 32'(instr_pc), 32'(m_exp_pc));
                chk("m_instr", instr, rom(m_exp_pc));
            end
            chk("m_req", 32'(imem_req), 32'(m_req));
            if (m_req) chk("m_addr", 32'(imem_addr), 32'(m_fetch_pc));
            if (m_redir) begin
                m_tgt      = (redirect_mode ? imm_op : m_exp_pc + imm_op) & 8'hFC;
                m_exp_pc   = m_tgt;
                m_fetch_pc = m_tgt;
                m_out      = 0;
                m_since    = 0;
            end else begin
                if (m_acc) begin
                    m_exp_pc = m_exp_pc + 8'd4;
                    m_out    = m_out - 1;
                end
                if (m_req) begin
                    m_fetch_pc = m_fetch_pc + 8'd4;
                    m_out      = m_out + 1;
                end
                if (m_since < 100) m_since = m_since + 1;
            end
        end
        prev_rst = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] pc);
        chk({name, "_valid"}, 32'(instr_valid), 32'd1);
        chk({name, "_pc"}, 32'(instr_pc), 32'(pc));
        chk({name, "_instr"}, instr, rom(pc));
    endtask

    task automatic redirect(input logic mode, input logic [7:0] imm);
        redirect_valid = 1'b1;
        redirect_mode  = mode;
        imm_op         = imm;
        step();
        redirect_valid = 1'b0;
        chk("redir_n1_valid", 32'(instr_valid), 32'd0);
        step();
        chk("redir_n2_valid", 32'(instr_valid), 32'd0);
        step();
    endtask

    initial begin
        repeat (3) step();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);

        // Cycle 0 after release.
        rst = 1'b0;
        instr_ready = 1'b1;
        #1;
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", 32'(imem_addr), 32'd0);
        step();
        chk("c1_valid", 32'(instr_valid), 32'd0);
        step();
        expect_out("c2", 8'h00);
        chk("c2_instr_lit", instr, 32'h0000_1000);
        step();
        expect_out("c3", 8'h04);
        chk("c3_instr_lit", instr, 32'h0000_1001);

        // Backpressure for three cycles at pc 8.
        step();
        expect_out("c4", 8'h08);
        instr_ready = 1'b0;
        #1 chk("stall_req0", 32'(imem_req), 32'd0);
        step();
        expect_out("hold1", 8'h08);
        chk("stall_req1", 32'(imem_req), 32'd0);
        step();
        expect_out("hold2", 8'h08);
        chk("stall_req2", 32'(imem_req), 32'd0);
        step();
        expect_out("hold3", 8'h08);
        instr_ready = 1'b1;
        step();
        expect_out("resume0", 8'h0C);
        step();
        expect_out("resume1", 8'h10);

        // Relative redirect from 0x10 by 0x20.
        redirect(1'b0, 8'h20);
        expect_out("rel", 8'h30);
        chk("rel_pc_lit", 32'(instr_pc), 32'h30);

        // Absolute redirect to a misaligned target.
        redirect(1'b1, 8'h47);
        expect_out("abs", 8'h44);
        chk("abs_pc_lit", 32'(instr_pc), 32'h44);

        // Redirect without accept must be ignored.
        instr_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_mode  = 1'b1;
        imm_op         = 8'h80;
        step();
        redirect_valid = 1'b0;
        expect_out("ign_hold", 8'h44);
        instr_ready = 1'b1;
        step();
        expect_out("ign_next", 8'h48);

        // Sequential wrap through the top of the address space.
        redirect(1'b1, 8'hF0);
        expect_out("wrap0", 8'hF0);
        step();
        expect_out("wrap1", 8'hF4);
        step();
        expect_out("wrap2", 8'hF8);
        step();
        expect_out("wrap3", 8'hFC);
        step();
        expect_out("wrap4", 8'h00);
        chk("wrap_instr_lit", instr, 32'h0000_1000);

        // Relative redirect that wraps.
        redirect(1'b1, 8'hF0);
        expect_out("relw0", 8'hF0);
        redirect(1'b0, 8'h20);
        expect_out("relw1", 8'h10);
        chk("relw_pc_lit", 32'(instr_pc), 32'h10);

        // Reset landing in the FLUSH cycle.
        redirect_valid = 1'b1;
        redirect_mode  = 1'b1;
        imm_op         = 8'h80;
        step();
        redirect_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rflush_v0", 32'(instr_valid), 32'd0);
        step();
        chk("rflush_v1", 32'(instr_valid), 32'd0);
        step();
        expect_out("rflush", 8'h00);

        // Randomized traffic checked by the stream model.
        repeat (3000) begin
            step();
            rst            = ($urandom_range(0, 299) == 0);
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_mode  = 1'($urandom_range(0, 1));
            imm_op         = 8'($urandom);
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
